// File: rtl/motion_update_velocity_broadcaster.sv
// Motion-update velocity broadcaster: walks all cells, reads v and f,
// and broadcasts saturated v + (f >>> DT_SHIFT) to the velocity caches.
module motion_update_velocity_broadcaster #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int PARTICLE_NUM  = 220,
  parameter int CELL_ID_WIDTH = 4,
  parameter int X_DIM         = 3,
  parameter int Y_DIM         = 3,
  parameter int Z_DIM         = 3,
  parameter int DT_SHIFT      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [3*CELL_ID_WIDTH-1:0] out_cell_id,
  output logic [ADDR_WIDTH-1:0]      out_read_address,
  output logic                       out_rden,
  input  logic [3*DATA_WIDTH-1:0]    in_velocity,
  input  logic [3*DATA_WIDTH-1:0]    in_force,
  input  logic [3*CELL_ID_WIDTH-1:0] in_dst_cell,
  output logic                       motion_update_enable,
  output logic [3*DATA_WIDTH-1:0]    out_data,
  output logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell,
  output logic                       out_data_valid,
  output logic                       done
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = CELL_ID_WIDTH;
  localparam int AW = ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    RD_NUM,
    WAIT_NUM,
    STREAM,
    DRAIN,
    NEXT_CELL,
    FINISH
  } state_t;

  state_t state;
  state_t state_nx;

  logic          phase;
  logic [AW-1:0] addr;
  logic [AW-1:0] count;
  logic [AW-1:0] count_in;
  logic [AW-1:0] count_clamp;
  logic [CW-1:0] cx;
  logic [CW-1:0] cy;
  logic [CW-1:0] cz;
  logic          last_cell;
  logic          tag1;
  logic          tag2;
  logic [3*DW-1:0] v_new;

  assign count_in    = in_velocity[AW-1:0];
  assign count_clamp = (count_in > AW'(PARTICLE_NUM)) ?
                       AW'(PARTICLE_NUM) : count_in;

  assign last_cell = (cx == CW'(X_DIM - 1)) &&
                     (cy == CW'(Y_DIM - 1)) &&
                     (cz == CW'(Z_DIM - 1));

  assign out_cell_id = {cx, cy, cz};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and read-port outputs
  always_comb begin
    state_nx             = state;
    out_rden             = 1'b0;
    out_read_address     = '0;
    done                 = 1'b0;
    motion_update_enable = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start) state_nx = RD_NUM;
      end
      RD_NUM: begin
        out_rden = 1'b1;
        state_nx = WAIT_NUM;
      end
      WAIT_NUM: begin
        if (phase) begin
          state_nx = (count_clamp == '0) ? NEXT_CELL : STREAM;
        end
      end
      STREAM: begin
        out_rden         = 1'b1;
        out_read_address = addr;
        if (addr == count) state_nx = DRAIN;
      end
      DRAIN: begin
        if (phase) state_nx = NEXT_CELL;
      end
      NEXT_CELL: begin
        state_nx = last_cell ? FINISH : RD_NUM;
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Cell walk, particle address and two-cycle wait phase
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= 1'b0;
      addr  <= '0;
      count <= '0;
      cx    <= '0;
      cy    <= '0;
      cz    <= '0;
    end else begin
      phase <= (state == WAIT_NUM || state == DRAIN) ? ~phase : 1'b0;
      if (state == IDLE && start) begin
        cx <= '0;
        cy <= '0;
        cz <= '0;
      end
      if (state == WAIT_NUM && phase) begin
        count <= count_clamp;
        addr  <= AW'(1);
      end
      if (state == STREAM && addr != count) addr <= addr + AW'(1);
      if (state == NEXT_CELL && !last_cell) begin
        if (cz == CW'(Z_DIM - 1)) begin
          cz <= '0;
          if (cy == CW'(Y_DIM - 1)) begin
            cy <= '0;
            cx <= cx + CW'(1);
          end else begin
            cy <= cy + CW'(1);
          end
        end else begin
          cz <= cz + CW'(1);
        end
      end
      if (state == FINISH) begin
        cx <= '0;
        cy <= '0;
        cz <= '0;
      end
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_comp
    logic signed [DW-1:0] v;
    logic signed [DW-1:0] f;
    logic signed [DW-1:0] fs;
    logic signed [DW:0]   sum;
    assign v   = in_velocity[i*DW +: DW];
    assign f   = in_force[i*DW +: DW];
    assign fs  = f >>> DT_SHIFT;
    assign sum = {v[DW-1], v} + {fs[DW-1], fs};
    assign v_new[i*DW +: DW] =
      (sum[DW] == sum[DW-1]) ? sum[DW-1:0] :
      sum[DW] ? {1'b1, {(DW-1){1'b0}}} :
                {1'b0, {(DW-1){1'b1}}};
  end

  // Read-tag pipeline and registered broadcast
  always_ff @(posedge clk) begin
    if (rst) begin
      tag1              <= 1'b0;
      tag2              <= 1'b0;
      out_data_valid    <= 1'b0;
      out_data          <= '0;
      out_data_dst_cell <= '0;
    end else begin
      tag1           <= (state == STREAM);
      tag2           <= tag1;
      out_data_valid <= tag2;
      if (tag2) begin
        out_data          <= v_new;
        out_data_dst_cell <= in_dst_cell;
      end
    end
  end

endmodule

// File: tb/tb_motion_update_velocity_broadcaster.sv
// Bench: cache model with 2-cycle read latency, table vectors,
// and a pass-level reference model for randomized cell contents.
module tb_motion_update_velocity_broadcaster;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [11:0]  out_cell_id;
  logic [7:0]   out_read_address;
  logic         out_rden;
  logic [95:0]  in_velocity;
  logic [95:0]  in_force;
  logic [11:0]  in_dst_cell;
  logic         motion_update_enable;
  logic [95:0]  out_data;
  logic [11:0]  out_data_dst_cell;
  logic         out_data_valid;
  logic         done;

  always #5 clk = ~clk;

  motion_update_velocity_broadcaster dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .out_cell_id          (out_cell_id),
    .out_read_address     (out_read_address),
    .out_rden             (out_rden),
    .in_velocity          (in_velocity),
    .in_force             (in_force),
    .in_dst_cell          (in_dst_cell),
    .motion_update_enable (motion_update_enable),
    .out_data             (out_data),
    .out_data_dst_cell    (out_data_dst_cell),
    .out_data_valid       (out_data_valid),
    .done                 (done)
  );

  // cache contents: [cell][addr]; vm[c][0][7:0] is the count
  logic [95:0] vm [27][256];
  logic [95:0] fm [27][256];
  logic [11:0] dm [27][256];

  function automatic int cidx(logic [11:0] c);
    return int'(c[11:8]) * 9 + int'(c[7:4]) * 3 + int'(c[3:0]);
  endfunction

  function automatic logic [11:0] cid(int c);
    return {4'(c / 9), 4'((c / 3) % 3), 4'(c % 3)};
  endfunction

  // cache model: data appears 2 cycles after the address
  logic [20:0] p1 = '0;
  logic [20:0] p2 = '0;
  always @(posedge clk) begin
    p1 <= {out_rden, out_cell_id, out_read_address};
    p2 <= p1;
  end

  always @* begin
    in_velocity = '0;
    in_force    = '0;
    in_dst_cell = '0;
    if (p2[20] && cidx(p2[19:8]) < 27) begin
      in_velocity = vm[cidx(p2[19:8])][p2[7:0]];
      in_force    = fm[cidx(p2[19:8])][p2[7:0]];
      in_dst_cell = dm[cidx(p2[19:8])][p2[7:0]];
    end
  end

  // monitor
  logic [95:0] got_d[$];
  logic [11:0] got_dst[$];
  int          got_cyc[$];
  logic [19:0] rd_q[$];
  int          rd_cyc[$];
  int cyc = 0;
  int en_cycles = 0;
  int done_cnt = 0;
  int en_viol = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (motion_update_enable) en_cycles++;
      if (done) done_cnt++;
      if (out_data_valid) begin
        got_d.push_back(out_data);
        got_dst.push_back(out_data_dst_cell);
        got_cyc.push_back(cyc);
        if (!motion_update_enable) en_viol++;
      end
      if (out_rden) begin
        rd_q.push_back({out_cell_id, out_read_address});
        rd_cyc.push_back(cyc);
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string n, input logic [127:0] g,
                     input logic [127:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, g, e);
    end
  endtask

  // reference arithmetic: plain integer sum, then clamp
  function automatic logic [31:0] sat(logic [31:0] v, logic [31:0] f);
    longint s;
    s = longint'($signed(v)) + (longint'($signed(f)) >>> 8);
    if (s > 64'sd2147483647) return 32'h7fffffff;
    if (s < -64'sd2147483648) return 32'h80000000;
    return s[31:0];
  endfunction

  function automatic logic [95:0] upd(logic [95:0] v, logic [95:0] f);
    logic [95:0] r;
    for (int k = 0; k < 3; k++)
      r[k*32 +: 32] = sat(v[k*32 +: 32], f[k*32 +: 32]);
    return r;
  endfunction

  function automatic logic [31:0] rnd_v();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0: r = 32'h7fff0000 + 32'($urandom_range(0, 65535));
      1: r = 32'h80000000 + 32'($urandom_range(0, 65535));
      default: r = $urandom;
    endcase
    return r;
  endfunction

  task automatic fill_random(input int maxcnt);
    for (int c = 0; c < 27; c++) begin
      for (int a = 0; a < 256; a++) begin
        vm[c][a] = {rnd_v(), rnd_v(), rnd_v()};
        fm[c][a] = {$urandom, $urandom, $urandom};
        dm[c][a] = 12'($urandom);
      end
      vm[c][0][7:0] = 8'($urandom_range(0, maxcnt));
    end
  endtask

  task automatic clear_mon();
    got_d.delete();
    got_dst.delete();
    got_cyc.delete();
    rd_q.delete();
    rd_cyc.delete();
    en_cycles = 0;
    done_cnt = 0;
    en_viol = 0;
  endtask

  task automatic run_pass(input string tag, input int mid);
    logic [95:0] exp_d[$];
    logic [11:0] exp_dst[$];
    logic [19:0] exp_rd[$];
    int exp_en;
    int n;
    int bad;
    exp_en = 1;
    for (int c = 0; c < 27; c++) begin
      n = int'(vm[c][0][7:0]);
      if (n > 220) n = 220;
      exp_rd.push_back({cid(c), 8'd0});
      exp_en += 4;
      if (n > 0) exp_en += n + 2;
      for (int a = 1; a <= n; a++) begin
        exp_rd.push_back({cid(c), 8'(a)});
        exp_d.push_back(upd(vm[c][a], fm[c][a]));
        exp_dst.push_back(dm[c][a]);
      end
    end
    clear_mon();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (done_cnt > 0) break;
      start = (mid != 0 && i == 30);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_done"}, 128'(done_cnt), 1);
    chk({tag, "_en_cycles"}, 128'(en_cycles), 128'(exp_en));
    chk({tag, "_nvalid"}, 128'(got_d.size()), 128'(exp_d.size()));
    bad = 0;
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++)
      if (got_d[i] !== exp_d[i] || got_dst[i] !== exp_dst[i]) begin
        if (bad == 0)
          $display("%s first diff #%0d got=%h/%h exp=%h/%h", tag, i,
                   got_d[i], got_dst[i], exp_d[i], exp_dst[i]);
        bad++;
      end
    chk({tag, "_data"}, 128'(bad), 0);
    bad = (rd_q.size() == exp_rd.size()) ? 0 : 1;
    for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
      if (rd_q[i] !== exp_rd[i]) bad++;
    chk({tag, "_reads"}, 128'(bad), 0);
    chk({tag, "_en_viol"}, 128'(en_viol), 0);
    chk({tag, "_idle"}, {motion_update_enable, out_data_valid, done}, 0);
  endtask

  typedef struct {
    logic [31:0] v;
    logic [31:0] f;
    logic [31:0] e;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int t;
    int n13;
    logic found;
    tbl[0] = '{32'd10,       32'd256,       32'd11};
    tbl[1] = '{32'd20,       32'd512,       32'd22};
    tbl[2] = '{32'd30,       32'hffffff00,  32'd29};
    tbl[3] = '{32'h7fffff00, 32'h00010000,  32'h7fffffff};
    tbl[4] = '{32'h80000010, 32'hffff0000,  32'h80000000};
    tbl[5] = '{32'd0,        32'hffffffff,  32'hffffffff};
    tbl[6] = '{32'h7fffffff, 32'd0,         32'h7fffffff};
    tbl[7] = '{32'd5,        32'd255,       32'd5};
    tbl[8] = '{32'h7fffff00, 32'h0000ff00,  32'h7fffffff};
    tbl[9] = '{32'hffffff9c, 32'hfffffe00,  32'hffffff9a};

    rst = 1'b1;
    start = 1'b0;
    fill_random(6);
    repeat (3) @(negedge clk);
    chk("reset_data", {out_data_dst_cell, out_data}, 0);
    chk("reset_ctl", {out_cell_id, out_read_address, out_rden,
                      motion_update_enable, out_data_valid, done}, 0);
    rst = 1'b0;
    @(negedge clk);

    // all cells empty
    for (int c = 0; c < 27; c++) vm[c][0][7:0] = 8'd0;
    run_pass("empty", 0);
    chk("empty_outs", {out_cell_id, out_read_address, out_rden,
                       out_data_dst_cell, out_data}, 0);

    // cell {0,0,1}: two particles; cell {0,0,2}: table vectors
    for (int c = 0; c < 27; c++) vm[c][0][7:0] = 8'd0;
    vm[1][0][7:0] = 8'd2;
    for (int a = 1; a <= 2; a++) begin
      vm[1][a] = {32'd30, 32'd20, 32'd10};
      fm[1][a] = {32'hffffff00, 32'd512, 32'd256};
    end
    vm[2][0][7:0] = 8'd10;
    for (int i = 0; i < 10; i++) begin
      vm[2][i+1] = {tbl[i].v, tbl[i].v, tbl[i].v};
      fm[2][i+1] = {tbl[i].f, tbl[i].f, tbl[i].f};
    end
    run_pass("vec", 0);
    for (int i = 0; i < 2; i++) begin
      chk("basic_data", got_d[i], {32'd29, 32'd22, 32'd11});
      chk("basic_dst", 128'(got_dst[i]), 128'(dm[1][i+1]));
    end
    t = -100;
    for (int i = 0; i < rd_q.size(); i++)
      if (rd_q[i] == {12'h001, 8'd1}) begin
        t = rd_cyc[i];
        break;
      end
    chk("latency", 128'(got_cyc.size() > 0 ? got_cyc[0] - t : -1), 3);
    chk("back2back", 128'(got_cyc.size() > 1 ?
                     got_cyc[1] - got_cyc[0] : -1), 1);
    for (int i = 0; i < 10; i++)
      chk("tbl", got_d[2+i], {tbl[i].e, tbl[i].e, tbl[i].e});

    // random contents, one over-full cell, start pulsed mid-pass
    fill_random(6);
    vm[13][0][7:0] = 8'd250;
    run_pass("clamp", 1);
    n13 = 0;
    for (int i = 0; i < rd_q.size(); i++)
      if (rd_q[i][19:8] == 12'h111 && rd_q[i][7:0] != 0) n13++;
    chk("clamp_reads", 128'(n13), 220);

    // reset in the middle of a stream
    fill_random(4);
    vm[0][0][7:0] = 8'd50;
    clear_mon();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (out_rden && out_read_address == 8'd5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_reach", 128'(found), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_abort_data", {out_data_dst_cell, out_data}, 0);
    chk("rst_abort_ctl", {out_cell_id, out_read_address, out_rden,
                          motion_update_enable, out_data_valid, done}, 0);
    @(negedge clk) rst = 1'b0;
    clear_mon();
    repeat (10) @(negedge clk);
    chk("rst_quiet", 128'(got_d.size() + en_cycles), 0);
    run_pass("after_rst", 0);

    // two passes back to back
    fill_random(5);
    run_pass("pass_a", 0);
    fill_random(5);
    run_pass("pass_b", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motion_update_velocity_broadcaster.md
Name: motion_update_velocity_broadcaster

Overview:
- Upstream sequencer for the per-cell velocity caches during motion update.
- Walks every cell and reads the particle count and each particle's velocity and force.
- Computes v_new = v + (f >>> DT_SHIFT) per component.
- Broadcasts v_new with its destination cell ID on the shared bus consumed by all velocity caches, and frames the run with motion_update_enable.

Parameters:
- DATA_WIDTH, 32: width of one signed fixed-point component.
- ADDR_WIDTH, 8: cache address width; address 0 holds the particle count.
- PARTICLE_NUM, 220: maximum particles per cell; larger counts are clamped.
- CELL_ID_WIDTH, 4: width of one cell coordinate.
- X_DIM, 3: number of cells in x.
- Y_DIM, 3: number of cells in y.
- Z_DIM, 3: number of cells in z.
- DT_SHIFT, 8: arithmetic right shift applied to force (dt scaling).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle pulse that begins a motion-update pass.
- out_cell_id  out  3*CELL_ID_WIDTH  source cell currently being read, {x,y,z}; drives the external read mux.
- out_read_address  out  ADDR_WIDTH  read address to the source velocity and force caches.
- out_rden  out  1  read enable to the caches.
- in_velocity  in  3*DATA_WIDTH  {vz,vy,vx}; valid 2 cycles after the address is issued.
- in_force  in  3*DATA_WIDTH  {fz,fy,fx}; same alignment as in_velocity.
- in_dst_cell  in  3*CELL_ID_WIDTH  destination cell from the position unit; same alignment as in_velocity.
- motion_update_enable  out  1  high for the whole broadcast window.
- out_data  out  3*DATA_WIDTH  {vz,vy,vx} new velocity.
- out_data_dst_cell  out  3*CELL_ID_WIDTH  destination cell of out_data.
- out_data_valid  out  1  broadcast qualifier.
- done  out  1  one-cycle pulse at the end of a pass.

Behaviour:
- Reset values: all outputs are 0 and state is IDLE. A reset asserted mid-pass aborts immediately; the next cycle is IDLE with all outputs 0 and no further broadcast.
- Cell order: z increments fastest, then y, then x; the pass starts at {0,0,0} and ends at {X_DIM-1,Y_DIM-1,Z_DIM-1}.
- IDLE: on start, set motion_update_enable=1, set the cell counters to 0 and go to RD_NUM. While not in IDLE, start is ignored.
- RD_NUM: drive out_rden=1 and address 0 for 1 cycle, then WAIT_NUM.
- WAIT_NUM: wait 2 cycles. On the second cycle, capture count = min(in_velocity[ADDR_WIDTH-1:0], PARTICLE_NUM).
  - count==0: go to NEXT_CELL.
  - otherwise: go to STREAM.
- STREAM: issue addresses 1..count, one per cycle, with out_rden=1, then DRAIN.
- DRAIN: 2 cycles so the last reads return, then NEXT_CELL.
- NEXT_CELL: advance the cell counters.
  - Last cell already done: go to FINISH.
  - Otherwise: go to RD_NUM.
- FINISH: drop motion_update_enable to 0, pulse done=1 for 1 cycle, then IDLE.
- Datapath:
  - A 2-stage valid shift register tracks each issued particle read.
  - When the tag arrives, compute the sum and register it into out_data, out_data_dst_cell and out_data_valid=1.
  - Latency from address issue to out_data_valid is 3 cycles.
  - The count read (address 0) is never broadcast.
  - When no tag arrives, out_data_valid=0 and out_data holds its previous value.
- Arithmetic, per component:
  - Form sign-extended (DATA_WIDTH+1)-bit v + (f >>> DT_SHIFT).
  - Saturate to 0x7FFFFFFF or 0x80000000 on overflow. There is no wrap-around.
- Framing guarantees:
  - motion_update_enable is high on every cycle that out_data_valid is high.
  - motion_update_enable falls exactly 1 cycle after the final valid, or 1 cycle after the last NEXT_CELL if no particles exist.
- A pass with all cells empty still asserts motion_update_enable, so the caches swap and write count 0.
- Throughput: 1 particle per cycle within a cell. Per-cell overhead is 5 cycles (RD_NUM, 2x WAIT_NUM, 2x DRAIN) plus 1 for NEXT_CELL.

Test Plan:
- Reset, then a start pulse with all 27 cells at count 0 -> no out_data_valid; motion_update_enable is high for 27*4+1 cycles; done pulses once; all outputs 0 afterwards.
- Cell {0,0,1} with count 2, v=(10,20,30), f=(256,512,-256) for both particles, DT_SHIFT=8 -> 2 consecutive valids with out_data={29,22,11} (vz,vy,vx order = 30-1, 20+2, 10+1) and dst equal to the supplied in_dst_cell; first valid 3 cycles after address 1 is issued.
- Saturation: v.x=0x7FFFFF00, f.x=0x00010000 -> out x=0x7FFFFFFF. v.y=0x80000010, f.y=0xFFFF0000 -> out y=0x80000000.
- Count 250 with PARTICLE_NUM=220 -> exactly 220 reads and valids for that cell; addresses 1..220.
- start asserted again mid-pass -> ignored, total valids unchanged. rst asserted during STREAM -> the next cycle has all outputs 0; a later start runs a full clean pass.
- Two back-to-back passes -> the second starts only after done; z-fastest cell order verified by out_cell_id sequence {0,0,0},{0,0,1},{0,0,2},{0,1,0}...
